// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 write sequencer (lcd_ctrl).
// The power-up init sequence is built only when LCD_CTRL_INIT_EN is defined.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
`ifdef LCD_CTRL_INIT_EN
    , S_PWRUP      = 3'd5
    , S_INIT_ISSUE = 3'd6
`endif
  } state_t;

  localparam int LCD_RW_BIT = 8;
  localparam int LCD_RS_BIT = 9;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_ON_BIT = 31;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  localparam int INIT_LEN = 4;

  // 4-entry init ROM: 8-bit/2-line, display on, clear, entry increment.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  // Clear and return-home need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d == CMD_CLEAR || d == CMD_HOME || d == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter with zero flag; holds at zero (no wrap-around).
module lcd_ctrl_timer #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write sequencer: setup / EN pulse / hold / exec wait per byte.
// Define LCD_CTRL_INIT_EN to add the power-up wait and built-in init command sequence.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int T_AS    = 3,
  parameter int T_PW    = 25,
  parameter int T_H     = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_PWRUP = 750000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic [31:0] lcd_o
);

  localparam int T_MAX = (T_CLR > T_PWRUP) ? T_CLR : T_PWRUP;
  localparam int TW    = $clog2(T_MAX) + 1;

  // Each state lasts (load value + 1) cycles, so load duration minus one.
  localparam logic [TW-1:0] LD_AS   = TW'(T_AS - 1);
  localparam logic [TW-1:0] LD_PW   = TW'(T_PW - 1);
  localparam logic [TW-1:0] LD_H    = TW'(T_H - 1);
  localparam logic [TW-1:0] LD_EXEC = TW'(T_EXEC - 1);
  localparam logic [TW-1:0] LD_CLR  = TW'(T_CLR - 1);

`ifdef LCD_CTRL_INIT_EN
  localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP - 1);
  localparam state_t        ST_RST   = S_PWRUP;
`else
  localparam logic [TW-1:0] LD_PWRUP = '0;
  localparam state_t        ST_RST   = S_IDLE;
`endif

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_zero;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_en;
  logic            r_on;
  logic            r_ready;
  logic            r_busy;
  logic            r_init_done;
`ifdef LCD_CTRL_INIT_EN
  logic            w_issue;
  logic [2:0]      r_init_idx;
`endif

  lcd_ctrl_timer #(
    .WIDTH   (TW),
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
`ifdef LCD_CTRL_INIT_EN
    w_issue  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_valid_i && r_ready) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: if (w_zero) w_next = S_PULSE;
      S_PULSE: if (w_zero) w_next = S_HOLD;
      S_HOLD:  if (w_zero) w_next = S_WAIT;
      S_WAIT: begin
        if (w_zero) begin
`ifdef LCD_CTRL_INIT_EN
          w_next = (r_init_idx != 3'(INIT_LEN)) ? S_INIT_ISSUE : S_IDLE;
`else
          w_next = S_IDLE;
`endif
        end
      end
`ifdef LCD_CTRL_INIT_EN
      S_PWRUP: if (w_zero) w_next = S_INIT_ISSUE;
      S_INIT_ISSUE: begin
        w_issue = 1'b1;
        w_next  = S_SETUP;
      end
`endif
      default: w_next = S_IDLE;
    endcase

    // Timer reloads on every state change with the new state's duration.
    w_load = (w_next != r_state);
    case (w_next)
      S_SETUP: w_load_val = LD_AS;
      S_PULSE: w_load_val = LD_PW;
      S_HOLD:  w_load_val = LD_H;
      S_WAIT:  w_load_val = is_slow_cmd(r_rs, r_data) ? LD_CLR : LD_EXEC;
      default: w_load_val = '0;
    endcase
  end

  // Registered outputs; EN trails the PULSE state by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rs        <= 1'b0;
      r_data      <= '0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_on        <= 1'b1;
      r_en        <= (r_state == S_PULSE);
      r_ready     <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_init_done <= r_init_done | (w_next == S_IDLE);
      if (w_accept) begin
        r_rs   <= req_rs_i;
        r_data <= req_data_i;
      end
`ifdef LCD_CTRL_INIT_EN
      else if (w_issue) begin
        r_rs   <= 1'b0;
        r_data <= init_cmd(r_init_idx[1:0]);
      end
`endif
    end
  end

`ifdef LCD_CTRL_INIT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        r_init_idx <= '0;
    else if (w_issue) r_init_idx <= r_init_idx + 3'd1;
  end
`endif

  always_comb begin
    lcd_o             = '0;
    lcd_o[7:0]        = r_data;
    lcd_o[LCD_RW_BIT] = 1'b0;
    lcd_o[LCD_RS_BIT] = r_rs;
    lcd_o[LCD_EN_BIT] = r_en;
    lcd_o[LCD_ON_BIT] = r_on;
  end

  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign init_done_o = r_init_done;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: randomized byte writes against a timing model.
// Honours LCD_CTRL_INIT_EN for the built-in init sequence.
`timescale 1ns/1ps
module tb_lcd_ctrl;
  import lcd_ctrl_pkg::*;

  localparam int T_AS    = 3;
  localparam int T_PW    = 25;
  localparam int T_H     = 2;
  localparam int T_EXEC  = 2000;
  localparam int T_CLR   = 4100;
  localparam int T_PWRUP = 10;
  localparam int LIMIT   = T_AS + T_PW + T_H + T_CLR + 50;

  typedef struct {
    int         start;
    int         len;
    logic [7:0] data;
    logic       rs;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rs;
  logic [7:0]  req_data;
  logic        busy;
  logic        init_done;
  logic [31:0] lcd;

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     glitches = 0;
  int     bad_bits = 0;
  int     rdy_busy = 0;
  pulse_t pq[$];

  lcd_ctrl #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
    .T_EXEC(T_EXEC), .T_CLR(T_CLR), .T_PWRUP(T_PWRUP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rs_i    (req_rs),
    .req_data_i  (req_data),
    .busy_o      (busy),
    .init_done_o (init_done),
    .lcd_o       (lcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference timing: cycles from the accept edge until ready returns.
  function automatic int ready_latency(input logic rs, input logic [7:0] d);
    bit slow;
    slow = (rs == 1'b0) && (d >= 8'h01) && (d <= 8'h03);
    return T_AS + T_PW + T_H + (slow ? T_CLR : T_EXEC);
  endfunction

  // Bus monitor: records every EN pulse and flags illegal bus activity.
  initial begin
    pulse_t     cur;
    logic       en_prev;
    logic       b_prev;
    logic [9:0] lo_prev;
    en_prev = 1'b0;
    b_prev  = 1'b0;
    lo_prev = '0;
    cur     = '{start: 0, len: 0, data: 8'h00, rs: 1'b0};
    forever begin
      @(negedge clk);
      if ((lcd & ~32'h8000_07FF) != 32'h0 || lcd[LCD_RW_BIT]) bad_bits++;
      if (req_ready && busy) rdy_busy++;
      if (((en_prev && lcd[LCD_EN_BIT]) || (busy && b_prev && init_done)) && lcd[9:0] != lo_prev)
        glitches++;
      if (lcd[LCD_EN_BIT]) begin
        if (!en_prev) begin
          cur.start = cyc;
          cur.len   = 0;
          cur.data  = lcd[7:0];
          cur.rs    = lcd[LCD_RS_BIT];
        end
        cur.len++;
      end else if (en_prev) begin
        pq.push_back(cur);
      end
      en_prev = lcd[LCD_EN_BIT];
      b_prev  = busy;
      lo_prev = lcd[9:0];
    end
  end

  // Called at a negedge; drives one byte and checks its whole bus transaction.
  task automatic send(input logic rs, input logic [7:0] d, input bit keep, input int poke,
                      output int acc, output int rdy);
    int     n;
    pulse_t p;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", req_ready, 1'b1);
    acc = cyc + 1;
    rdy = acc;
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("ready_after_accept", req_ready, 1'b0);
    n = 1;
    while (!req_ready && n < LIMIT) begin
      if (poke != 0 && n == poke) begin
        req_data  = 8'hFF;
        req_valid = 1'b1;
      end
      if (poke != 0 && n == poke + 1) req_valid = keep;
      @(negedge clk);
      n++;
    end
    rdy = cyc;
    check_eq("ready_wait", req_ready, 1'b1);
    check_eq("ready_latency", rdy - acc, ready_latency(rs, d));
    check_eq("idle_data", lcd[7:0], d);
    check_eq("idle_rs", lcd[LCD_RS_BIT], rs);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("pulse_count", pq.size(), 1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      check_eq("en_delay", p.start - acc, T_AS + 1);
      check_eq("en_width", p.len, T_PW);
      check_eq("en_data", p.data, d);
      check_eq("en_rs", p.rs, rs);
    end
    pq.delete();
  endtask

`ifdef LCD_CTRL_INIT_EN
  task automatic wait_init();
    logic [7:0] exp_init [4];
    pulse_t     p;
    int         n;
    int         k;
    exp_init = '{8'h38, 8'h0C, 8'h01, 8'h06};
    check_eq("init_busy", busy, 1'b1);
    check_eq("init_pending", init_done, 1'b0);
    n = 0;
    while (!init_done && n < T_PWRUP + 4 * LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_eq("init_done", init_done, 1'b1);
    check_eq("init_ready", req_ready, 1'b1);
    check_eq("init_pulses", pq.size(), 4);
    k = 0;
    while (pq.size() > 0 && k < 4) begin
      p = pq.pop_front();
      check_eq("init_cmd", p.data, exp_init[k]);
      check_eq("init_rs", p.rs, 1'b0);
      check_eq("init_width", p.len, T_PW);
      k++;
    end
    pq.delete();
  endtask
`endif

  task automatic startup_rule();
`ifdef LCD_CTRL_INIT_EN
    wait_init();
`else
    check_eq("start_init_done", init_done, 1'b1);
    check_eq("start_ready", req_ready, 1'b1);
    check_eq("start_busy", busy, 1'b0);
`endif
  endtask

  initial begin
    int         acc;
    int         rdy;
    int         prev_rdy;
    bit         prev_keep;
    bit         keep;
    logic       rs;
    logic [7:0] d;
    int         n;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_lcd", lcd, 32'h0);
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_init_done", init_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("on_after_release", lcd[LCD_ON_BIT], 1'b1);
    startup_rule();

    send(1'b1, 8'h41, 1'b0, 0, acc, rdy);
    send(1'b0, 8'h01, 1'b0, 0, acc, rdy);
    send(1'b0, 8'h00, 1'b0, 0, acc, rdy);

    send(1'b1, 8'h48, 1'b1, 0, acc, rdy);
    prev_rdy = rdy;
    send(1'b1, 8'h49, 1'b0, 0, acc, rdy);
    check_eq("b2b_accept", acc, prev_rdy + 1);

    send(1'b1, 8'h5A, 1'b0, T_AS + 5, acc, rdy);

    prev_keep = 1'b0;
    prev_rdy  = 0;
    for (int i = 0; i < 10; i++) begin
      rs   = 1'($urandom_range(0, 1));
      d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      keep = (i != 9) && ($urandom_range(0, 1) == 1);
      send(rs, d, keep, 0, acc, rdy);
      if (prev_keep) check_eq("rand_b2b_accept", acc, prev_rdy + 1);
      prev_keep = keep;
      prev_rdy  = rdy;
    end

    req_rs    = 1'b1;
    req_data  = 8'h55;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!lcd[LCD_EN_BIT] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("en_before_reset", lcd[LCD_EN_BIT], 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_lcd", lcd, 32'h0);
    check_eq("async_rst_ready", req_ready, 1'b0);
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_init", init_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("on_after_rst", lcd[LCD_ON_BIT], 1'b1);
    pq.delete();
    startup_rule();
    send(1'b1, 8'h7E, 1'b0, 0, acc, rdy);

    check_eq("data_stable", glitches, 0);
    check_eq("reserved_bits", bad_bits, 0);
    check_eq("ready_while_busy", rdy_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
